// File: rtl/alu_arbiter.sv
// Two-requester front end for a single shared ALU: round-robin grant, one-cycle
// execute slot, and a registered response held until the consumer accepts it.
module alu_arbiter #(
  parameter int N_BITS         = 32,
  parameter int N_BITS_CONTROL = 5
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic                      i_req0_valid,
  input  logic [N_BITS-1:0]         i_req0_dato_A,
  input  logic [N_BITS-1:0]         i_req0_dato_B,
  input  logic [N_BITS_CONTROL-1:0] i_req0_ctrl,
  output logic                      o_req0_ready,
  input  logic                      i_req1_valid,
  input  logic [N_BITS-1:0]         i_req1_dato_A,
  input  logic [N_BITS-1:0]         i_req1_dato_B,
  input  logic [N_BITS_CONTROL-1:0] i_req1_ctrl,
  output logic                      o_req1_ready,
  output logic [N_BITS-1:0]         o_alu_dato_A,
  output logic [N_BITS-1:0]         o_alu_dato_B,
  output logic [N_BITS_CONTROL-1:0] o_alu_ctrl,
  input  logic [N_BITS-1:0]         i_alu_result,
  input  logic                      i_alu_zero,
  output logic                      o_resp_valid,
  output logic                      o_resp_id,
  output logic [N_BITS-1:0]         o_resp_result,
  output logic                      o_resp_zero,
  output logic                      o_resp_illegal,
  input  logic                      i_resp_ready,
  output logic                      o_busy
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  // Highest opcode the shared ALU implements.
  localparam logic [N_BITS_CONTROL-1:0] LAST_OP = N_BITS_CONTROL'(19);

  state_t                    state;
  logic                      prio;
  logic [N_BITS-1:0]         op_a;
  logic [N_BITS-1:0]         op_b;
  logic [N_BITS_CONTROL-1:0] op_ctrl;
  logic                      op_id;
  logic [N_BITS-1:0]         res;
  logic                      res_zero;
  logic                      res_illegal;
  logic                      grant0;
  logic                      grant1;

  // Grants are gated by reset so no ready leaks out while i_rst_n is low.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (i_rst_n && state == IDLE) begin
      grant0 = i_req0_valid && (!i_req1_valid || !prio);
      grant1 = i_req1_valid && (!i_req0_valid || prio);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= IDLE;
      prio        <= 1'b0;
      op_a        <= '0;
      op_b        <= '0;
      op_ctrl     <= '0;
      op_id       <= 1'b0;
      res         <= '0;
      res_zero    <= 1'b0;
      res_illegal <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant0) begin
            op_a    <= i_req0_dato_A;
            op_b    <= i_req0_dato_B;
            op_ctrl <= i_req0_ctrl;
            op_id   <= 1'b0;
            prio    <= 1'b1;
            state   <= EXEC;
          end else if (grant1) begin
            op_a    <= i_req1_dato_A;
            op_b    <= i_req1_dato_B;
            op_ctrl <= i_req1_ctrl;
            op_id   <= 1'b1;
            prio    <= 1'b0;
            state   <= EXEC;
          end
        end
        EXEC: begin
          res         <= i_alu_result;
          res_zero    <= i_alu_zero;
          res_illegal <= (op_ctrl > LAST_OP);
          state       <= RESP;
        end
        RESP: begin
          if (i_resp_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign o_req0_ready   = grant0;
  assign o_req1_ready   = grant1;
  assign o_alu_dato_A   = op_a;
  assign o_alu_dato_B   = op_b;
  assign o_alu_ctrl     = op_ctrl;
  assign o_resp_valid   = (state == RESP);
  assign o_resp_id      = op_id;
  assign o_resp_result  = res;
  assign o_resp_zero    = res_zero;
  assign o_resp_illegal = res_illegal;
  assign o_busy         = (state != IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: behavioural ALU on the shared port, scoreboard of
// expected responses pushed at request handshake and checked at response handshake.
module tb_alu_arbiter;

  typedef struct packed {
    logic        id;
    logic [31:0] result;
    logic        zero;
    logic        illegal;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0_valid, req1_valid;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic [4:0]  req0_ctrl, req1_ctrl;
  logic        req0_ready, req1_ready;
  logic [31:0] alu_a, alu_b, alu_result;
  logic [4:0]  alu_ctrl;
  logic        alu_zero;
  logic        resp_valid, resp_id, resp_zero, resp_illegal, resp_ready, busy;
  logic [31:0] resp_result;

  int   tests = 0;
  int   fails = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  function automatic logic [31:0] alu_fn(logic [31:0] a, logic [31:0] b, logic [4:0] c);
    case (c)
      5'd0:    return a & b;
      5'd1:    return a | b;
      5'd2:    return a + b;
      5'd6:    return a - b;
      5'd7:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  function automatic exp_t expect_op(logic id, logic [31:0] a, logic [31:0] b, logic [4:0] c);
    logic [31:0] r;
    r = alu_fn(a, b, c);
    return '{id: id, result: r, zero: (r == 32'd0), illegal: (c > 5'd19)};
  endfunction

  assign alu_result = alu_fn(alu_a, alu_b, alu_ctrl);
  assign alu_zero   = (alu_result == 32'd0);

  alu_arbiter #(.N_BITS(32), .N_BITS_CONTROL(5)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_req0_valid(req0_valid), .i_req0_dato_A(req0_a), .i_req0_dato_B(req0_b),
    .i_req0_ctrl(req0_ctrl), .o_req0_ready(req0_ready),
    .i_req1_valid(req1_valid), .i_req1_dato_A(req1_a), .i_req1_dato_B(req1_b),
    .i_req1_ctrl(req1_ctrl), .o_req1_ready(req1_ready),
    .o_alu_dato_A(alu_a), .o_alu_dato_B(alu_b), .o_alu_ctrl(alu_ctrl),
    .i_alu_result(alu_result), .i_alu_zero(alu_zero),
    .o_resp_valid(resp_valid), .o_resp_id(resp_id), .o_resp_result(resp_result),
    .o_resp_zero(resp_zero), .o_resp_illegal(resp_illegal),
    .i_resp_ready(resp_ready), .o_busy(busy)
  );

  // Called at a falling edge after inputs are driven; samples handshakes for the
  // coming rising edge, then advances to the next falling edge.
  task automatic step();
    exp_t e;
    #1;
    if (rst_n) begin
      if (req0_valid && req0_ready) sb.push_back(expect_op(1'b0, req0_a, req0_b, req0_ctrl));
      if (req1_valid && req1_ready) sb.push_back(expect_op(1'b1, req1_a, req1_b, req1_ctrl));
      if (resp_valid && resp_ready) begin
        tests++;
        if (sb.size() == 0) begin
          fails++;
          $display("FAIL resp_unexpected: got id=%0d result=%0h with nothing pending", resp_id, resp_result);
        end else begin
          e = sb.pop_front();
          if ({resp_id, resp_result, resp_zero, resp_illegal} !== e) begin
            fails++;
            $display("FAIL resp_fields: got id=%0d res=%0h zero=%0d ill=%0d, want id=%0d res=%0h zero=%0d ill=%0d",
                     resp_id, resp_result, resp_zero, resp_illegal, e.id, e.result, e.zero, e.illegal);
          end
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic drain();
    for (int i = 0; i < 30 && sb.size() != 0; i++) step();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    sb.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic issue(logic id, logic [31:0] a, logic [31:0] b, logic [4:0] c);
    int i;
    if (id) begin req1_a = a; req1_b = b; req1_ctrl = c; req1_valid = 1'b1; end
    else    begin req0_a = a; req0_b = b; req0_ctrl = c; req0_valid = 1'b1; end
    for (i = 0; i < 20; i++) begin
      #1;
      if (id ? req1_ready : req0_ready) break;
      step();
    end
    tests++;
    if (i == 20) begin fails++; $display("FAIL issue_timeout: req%0d never got ready", id); end
    step();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    drain();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    #1;
    tests++;
    if ({req0_ready, req1_ready, resp_valid, resp_id, resp_zero, resp_illegal, busy} !== 7'b0) begin
      fails++;
      $display("FAIL reset_ctrl: got %b want 0000000",
               {req0_ready, req1_ready, resp_valid, resp_id, resp_zero, resp_illegal, busy});
    end
    tests++;
    if ({resp_result, alu_a, alu_b, alu_ctrl} !== '0) begin
      fails++;
      $display("FAIL reset_data: res=%0h a=%0h b=%0h ctrl=%0h want 0", resp_result, alu_a, alu_b, alu_ctrl);
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    req0_a = 32'd5; req0_b = 32'd7; req0_ctrl = 5'b00010; req0_valid = 1'b1;
    #1;
    tests++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      fails++; $display("FAIL single_ready: got %b want 10", {req0_ready, req1_ready});
    end
    step();
    req0_valid = 1'b0;
    #1;
    tests++;
    if ({busy, resp_valid, req0_ready, req1_ready} !== 4'b1000) begin
      fails++; $display("FAIL single_exec: busy/valid/rdy got %b want 1000", {busy, resp_valid, req0_ready, req1_ready});
    end
    step();
    #1;
    tests++;
    if ({resp_valid, resp_result} !== {1'b1, 32'd12}) begin
      fails++; $display("FAIL single_latency: valid=%0d res=%0d want valid=1 res=12", resp_valid, resp_result);
    end
    step();
    #1;
    tests++;
    if ({resp_valid, busy} !== 2'b00) begin
      fails++; $display("FAIL single_release: valid/busy got %b want 00", {resp_valid, busy});
    end
  endtask

  task automatic test_priority();
    int i;
    do_reset();
    req0_a = 32'd9; req0_b = 32'd9; req0_ctrl = 5'b00111; req0_valid = 1'b1;
    req1_a = 32'd3; req1_b = 32'd4; req1_ctrl = 5'b00001; req1_valid = 1'b1;
    #1;
    tests++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      fails++; $display("FAIL prio_first: got %b want 10", {req0_ready, req1_ready});
    end
    step();
    req0_valid = 1'b0;
    for (i = 0; i < 20; i++) begin
      #1;
      if (req1_ready) break;
      step();
    end
    tests++;
    if (i == 20) begin fails++; $display("FAIL prio_second: req1 never granted"); end
    step();
    req1_valid = 1'b0;
    drain();
  endtask

  task automatic test_round_robin();
    int grants = 0;
    int last = 0;
    logic want = 1'b0;
    logic g;
    do_reset();
    req0_a = $urandom; req0_b = $urandom; req0_ctrl = 5'd2; req0_valid = 1'b1;
    req1_a = $urandom; req1_b = $urandom; req1_ctrl = 5'd6; req1_valid = 1'b1;
    for (int cyc = 0; cyc < 40 && grants < 6; cyc++) begin
      #1;
      g = 1'b0;
      if (req0_ready || req1_ready) begin
        g = 1'b1;
        tests++;
        if (req1_ready !== want) begin
          fails++; $display("FAIL rr_order: grant %0d went to req%0d want req%0d", grants, req1_ready, want);
        end
        if (grants > 0) begin
          tests++;
          if (cyc - last != 3) begin
            fails++; $display("FAIL rr_spacing: %0d cycles between grants want 3", cyc - last);
          end
        end
        last = cyc;
        want = ~want;
        grants++;
      end
      step();
      if (g) begin
        if (want) begin req0_a = $urandom; req0_b = $urandom; end
        else      begin req1_a = $urandom; req1_b = $urandom; end
      end
    end
    tests++;
    if (grants != 6) begin fails++; $display("FAIL rr_count: %0d grants want 6", grants); end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    drain();
  endtask

  task automatic test_stall();
    logic [34:0] held;
    int i;
    resp_ready = 1'b0;
    req1_a = 32'd10; req1_b = 32'd3; req1_ctrl = 5'd6; req1_valid = 1'b1;
    step();
    req1_valid = 1'b0;
    for (i = 0; i < 10 && !resp_valid; i++) step();
    tests++;
    if (!resp_valid) begin fails++; $display("FAIL stall_wait: no response appeared"); end
    held = {resp_id, resp_result, resp_zero, resp_illegal};
    req0_a = 32'd1; req0_b = 32'd1; req0_ctrl = 5'd2; req0_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      tests++;
      if ({resp_valid, busy, req0_ready, req1_ready, resp_id, resp_result, resp_zero, resp_illegal}
          !== {4'b1100, held}) begin
        fails++;
        $display("FAIL stall_hold: cycle %0d valid=%0d busy=%0d rdy=%b fields=%0h want fields=%0h",
                 k, resp_valid, busy, {req0_ready, req1_ready},
                 {resp_id, resp_result, resp_zero, resp_illegal}, held);
      end
      step();
    end
    req0_valid = 1'b0;
    resp_ready = 1'b1;
    step();
    #1;
    tests++;
    if (resp_valid !== 1'b0) begin fails++; $display("FAIL stall_release: valid=%0d want 0", resp_valid); end
  endtask

  task automatic test_illegal();
    issue(1'b0, 32'd1, 32'd1, 5'b11111);
    issue(1'b1, 32'd4, 32'd6, 5'b10011);
    issue(1'b0, 32'd4, 32'd6, 5'b10100);
    issue(1'b1, 32'hFFFF_FFFF, 32'd1, 5'd2);
  endtask

  task automatic test_reset_mid();
    req0_a = 32'd8; req0_b = 32'd8; req0_ctrl = 5'd2; req0_valid = 1'b1;
    step();
    req0_valid = 1'b0;
    #1;
    tests++;
    if ({busy, resp_valid} !== 2'b10) begin fails++; $display("FAIL midrst_exec: busy/valid %b want 10", {busy, resp_valid}); end
    req1_a = 32'd2; req1_b = 32'd3; req1_ctrl = 5'b00010; req1_valid = 1'b1;
    rst_n = 1'b0;
    #1;
    tests++;
    if ({req0_ready, req1_ready, resp_valid, resp_id, resp_zero, resp_illegal, busy, resp_result, alu_a, alu_b, alu_ctrl}
        !== '0) begin
      fails++;
      $display("FAIL midrst_outputs: rdy=%b valid=%0d busy=%0d res=%0h a=%0h want all 0",
               {req0_ready, req1_ready}, resp_valid, busy, resp_result, alu_a);
    end
    sb.delete();
    repeat (2) @(negedge clk);
    tests++;
    if (resp_valid !== 1'b0) begin fails++; $display("FAIL midrst_noresp: valid=%0d want 0", resp_valid); end
    rst_n = 1'b1;
    #1;
    tests++;
    if ({req0_ready, req1_ready} !== 2'b01) begin
      fails++; $display("FAIL midrst_regrant: got %b want 01", {req0_ready, req1_ready});
    end
    step();
    req1_valid = 1'b0;
    drain();
  endtask

  initial begin
    rst_n = 1'b0; resp_ready = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_a = '0; req0_b = '0; req0_ctrl = '0;
    req1_a = '0; req1_b = '0; req1_ctrl = '0;
    @(negedge clk);
    test_reset();
    test_single();
    test_priority();
    test_round_robin();
    test_stall();
    test_illegal();
    test_reset_mid();
    tests++;
    if (sb.size() != 0) begin fails++; $display("FAIL sb_drain: %0d responses never arrived", sb.size()); end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
